mpmc11_rmw_merge: RTL

- Read-modify-write data merger on the controller write path.
- Captures a partial write (data plus byte enables), waits for the read of the same line to return, and merges the write bytes over the read bytes.
- Presents the merged full line to the write datapath with all bytes enabled.
- Sits between the read-return datapath and the write data/mask generator; consumes read data and produces write data.

---
 rtl/mpmc11_rmw_merge.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mpmc11_rmw_merge.sv
// Read-modify-write merger: captures a partial write, waits for the line read, and emits the merged full line.
// Optional MPMC11_RMW_BYPASS_EN: full-mask writes skip the read and go straight to output.
module mpmc11_rmw_merge #(
  parameter int WID     = 256,
  parameter int MASKW   = WID/8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WID-1:0]   wdat_i,
  input  logic [MASKW-1:0] wmask_i,
  input  logic             rd_valid,
  input  logic [WID-1:0]   rd_dat,
  output logic             busy,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [WID-1:0]   wr_dat,
  output logic [MASKW-1:0] wr_mask,
  output logic             err
);
  localparam int CW = $clog2(TIMEOUT+1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WID-1:0]   r_wdat, w_wdat_nxt, r_dat, w_dat_nxt, w_merged;
  logic [MASKW-1:0] r_wmask, w_wmask_nxt, r_mask, w_mask_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_busy, r_vld, r_err, w_err_nxt, w_full;

`ifdef MPMC11_RMW_BYPASS_EN
  assign w_full = &wmask_i;
`else
  assign w_full = 1'b0;
`endif

  assign w_cnt_inc = r_cnt + CW'(1);

  // Captured write bytes win over read-return bytes.
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < MASKW; i++)
      w_merged[8*i +: 8] = r_wmask[i] ? r_wdat[8*i +: 8] : rd_dat[8*i +: 8];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wdat_nxt  = r_wdat;
    w_wmask_nxt = r_wmask;
    w_dat_nxt   = r_dat;
    w_mask_nxt  = r_mask;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_wdat_nxt  = wdat_i;
          w_wmask_nxt = wmask_i;
          w_cnt_nxt   = '0;
          if (w_full) begin
            w_dat_nxt   = wdat_i;
            w_mask_nxt  = '0;
            w_state_nxt = S_OUT;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_err_nxt = start;
        if (rd_valid) begin
          w_dat_nxt   = w_merged;
          w_mask_nxt  = '0;
          w_state_nxt = S_OUT;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(TIMEOUT)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_OUT: begin
        w_err_nxt = start;
        if (wr_ready) begin
          w_mask_nxt  = '1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wdat  <= '0;
      r_wmask <= '0;
      r_dat   <= '0;
      r_mask  <= '1;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wdat  <= w_wdat_nxt;
      r_wmask <= w_wmask_nxt;
      r_dat   <= w_dat_nxt;
      r_mask  <= w_mask_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_vld   <= (w_state_nxt == S_OUT);
      r_err   <= w_err_nxt;
    end
  end

  assign busy     = r_busy;
  assign wr_valid = r_vld;
  assign wr_dat   = r_dat;
  assign wr_mask  = r_mask;
  assign err      = r_err;
endmodule
